// File: rtl/img_rsz_pkg.sv
// Types and constants shared by the pixel-stream source and the resizer.
package img_rsz_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pxl_st_state_e;

  localparam int PXL_ST_FIFO_DEPTH = 4;

endpackage

// File: rtl/pxl_st_fifo.sv
// Small synchronous FIFO buffering frame-memory read data ahead of the pixel output.
module pxl_st_fifo
  import img_rsz_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = PXL_ST_FIFO_DEPTH
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             push_i,
  input  logic [DATA_W-1:0]                push_data_i,
  input  logic                             pop_i,
  output logic [DATA_W-1:0]                head_o,
  output logic                             empty_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  // Pointers wrap naturally, so DEPTH is expected to be a power of two.
  always_comb begin
    pop_ok   = pop_i && (cnt_q != '0);
    push_ok  = push_i && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge Clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/img_pxl_st_src.sv
// Pixel-stream source: reads a stored frame in raster order and streams it with X/Y
// coordinates over a valid/ready interface, keeping at most FIFO-depth reads outstanding.
module img_pxl_st_src
  import img_rsz_pkg::*;
#(
  parameter int IMG_WIDTH_MAX_SIZE  = 1024,
  parameter int IMG_HEIGHT_MAX_SIZE = 1024,
  parameter int IMG_WIDTH_IDX_W     = $clog2(IMG_WIDTH_MAX_SIZE),
  parameter int IMG_HEIGHT_IDX_W    = $clog2(IMG_HEIGHT_MAX_SIZE),
  parameter int PXL_PRIM_COLOR_NUM  = 1,
  parameter int PXL_PRIM_COLOR_W    = 8,
  parameter int MEM_ADDR_W          = IMG_WIDTH_IDX_W + IMG_HEIGHT_IDX_W
) (
  input  logic                                         Clk,
  input  logic                                         Reset,
  input  logic                                         StartVld,
  output logic                                         StartRdy,
  input  logic [IMG_WIDTH_IDX_W-1:0]                   ImgWidth,
  input  logic [IMG_HEIGHT_IDX_W-1:0]                  ImgHeight,
  output logic                                         MemRdEn,
  output logic [MEM_ADDR_W-1:0]                        MemRdAddr,
  input  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] MemRdData,
  output logic [PXL_PRIM_COLOR_W-1:0]                  PxlData [PXL_PRIM_COLOR_NUM],
  output logic [IMG_WIDTH_IDX_W-1:0]                   PxlX,
  output logic [IMG_HEIGHT_IDX_W-1:0]                  PxlY,
  output logic [IMG_WIDTH_IDX_W-1:0]                   StImgWidth,
  output logic [IMG_HEIGHT_IDX_W-1:0]                  StImgHeight,
  output logic                                         PxlVld,
  input  logic                                         PxlRdy,
  output logic                                         Done
);

  localparam int PXL_W = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;
  localparam int CNT_W = $clog2(PXL_ST_FIFO_DEPTH + 1);

  pxl_st_state_e               state_q, state_d;
  logic [IMG_WIDTH_IDX_W-1:0]  width_q, width_d, x_q, x_d;
  logic [IMG_HEIGHT_IDX_W-1:0] height_q, height_d, y_q, y_d;
  logic [MEM_ADDR_W-1:0]       total_q, total_d, rd_addr_q, rd_addr_d;
  logic                        inflight_q, done_q, done_d;
  logic                        start_hs, zero_size, pxl_hs, last_x, last_pxl, rd_en;
  logic [CNT_W-1:0]            fifo_cnt, occ;
  logic                        fifo_empty;
  logic [PXL_W-1:0]            fifo_head;

  assign start_hs  = StartVld && StartRdy;
  assign zero_size = (ImgWidth == '0) || (ImgHeight == '0);
  assign pxl_hs    = PxlVld && PxlRdy;
  assign last_x    = (x_q == width_q - IMG_WIDTH_IDX_W'(1));
  assign last_pxl  = last_x && (y_q == height_q - IMG_HEIGHT_IDX_W'(1));
  // Occupancy is taken at the start of the cycle; a pop in the same cycle earns no credit.
  assign occ       = fifo_cnt + CNT_W'(inflight_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_hs && !zero_size) state_d = ST_RUN;
      ST_RUN:  if (pxl_hs && last_pxl)     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    StartRdy = (state_q == ST_IDLE);
    rd_en    = (state_q == ST_RUN) && (occ < CNT_W'(PXL_ST_FIFO_DEPTH)) &&
               (rd_addr_q < total_q);
  end

  always_comb begin
    width_d   = width_q;
    height_d  = height_q;
    total_d   = total_q;
    rd_addr_d = rd_addr_q;
    x_d       = x_q;
    y_d       = y_q;
    done_d    = 1'b0;
    if (start_hs) begin
      width_d   = ImgWidth;
      height_d  = ImgHeight;
      total_d   = MEM_ADDR_W'(ImgWidth) * MEM_ADDR_W'(ImgHeight);
      rd_addr_d = '0;
      x_d       = '0;
      y_d       = '0;
      done_d    = zero_size;
    end else begin
      if (rd_en) rd_addr_d = rd_addr_q + MEM_ADDR_W'(1);
      if (pxl_hs) begin
        if (last_x) begin
          x_d = '0;
          y_d = y_q + IMG_HEIGHT_IDX_W'(1);
        end else begin
          x_d = x_q + IMG_WIDTH_IDX_W'(1);
        end
      end
      done_d = pxl_hs && last_pxl;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      width_q    <= '0;
      height_q   <= '0;
      total_q    <= '0;
      rd_addr_q  <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      width_q    <= width_d;
      height_q   <= height_d;
      total_q    <= total_d;
      rd_addr_q  <= rd_addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= rd_en;
      done_q     <= done_d;
    end
  end

  // Read data lands one cycle after issue and is pushed unconditionally; the
  // issue throttle guarantees the FIFO has room for it.
  pxl_st_fifo #(
    .DATA_W (PXL_W),
    .DEPTH  (PXL_ST_FIFO_DEPTH)
  ) u_fifo (
    .Clk         (Clk),
    .Reset       (Reset),
    .push_i      (inflight_q),
    .push_data_i (MemRdData),
    .pop_i       (pxl_hs),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  always_comb begin
    for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
      PxlData[c] = PxlVld ? fifo_head[c*PXL_PRIM_COLOR_W +: PXL_PRIM_COLOR_W] : '0;
    end
  end

  assign PxlVld      = !fifo_empty;
  assign MemRdEn     = rd_en;
  assign MemRdAddr   = rd_addr_q;
  assign PxlX        = x_q;
  assign PxlY        = y_q;
  assign StImgWidth  = width_q;
  assign StImgHeight = height_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_img_pxl_st_src.sv
// Directed bench for img_pxl_st_src with a one-cycle-latency frame memory returning address bits.
module tb_img_pxl_st_src;

  logic       clk = 1'b0;
  logic       rst, start_vld, start_rdy, mem_rd_en, pxl_vld, pxl_rdy, done;
  logic [9:0] img_w, img_h, pxl_x, pxl_y, st_w, st_h;
  logic [19:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  pxl_data [1];

  int checks = 0;
  int errors = 0;
  int issued = 0;
  int accepted = 0;
  int occ_viol = 0;

  always #5 clk = ~clk;

  img_pxl_st_src dut (
    .Clk         (clk),
    .Reset       (rst),
    .StartVld    (start_vld),
    .StartRdy    (start_rdy),
    .ImgWidth    (img_w),
    .ImgHeight   (img_h),
    .MemRdEn     (mem_rd_en),
    .MemRdAddr   (mem_addr),
    .MemRdData   (mem_data),
    .PxlData     (pxl_data),
    .PxlX        (pxl_x),
    .PxlY        (pxl_y),
    .StImgWidth  (st_w),
    .StImgHeight (st_h),
    .PxlVld      (pxl_vld),
    .PxlRdy      (pxl_rdy),
    .Done        (done)
  );

  // Frame memory: each location holds the low byte of its own address.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data <= mem_addr[7:0];
  end

  // Outstanding reads (in FIFO or in flight) must never exceed four when a read issues.
  always @(posedge clk) begin
    if (rst) begin
      issued   <= 0;
      accepted <= 0;
    end else begin
      if (mem_rd_en && (issued - accepted) >= 4) occ_viol <= occ_viol + 1;
      if (mem_rd_en) issued <= issued + 1;
      if (pxl_vld && pxl_rdy) accepted <= accepted + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int w, input int h);
    img_w     = 10'(w);
    img_h     = 10'(h);
    start_vld = 1'b1;
    step();
    start_vld = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start_rdy"}, 32'(start_rdy), 32'd1);
    check({tag, "_pxl_vld"},   32'(pxl_vld),   32'd0);
    check({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_xy"},        {12'd0, pxl_y, pxl_x}, 32'd0);
    check({tag, "_addr"},      32'(mem_addr),  32'd0);
    check({tag, "_st_wh"},     {12'd0, st_h, st_w}, 32'd0);
    check({tag, "_data"},      32'(pxl_data[0]), 32'd0);
  endtask

  // Called in the cycle after the start handshake; returns in the Done cycle.
  task automatic stream(input int w, input int h, input int stall_max,
                        input int exp_steps, input string tag);
    int n = 0;
    int cyc = 0;
    int stall;
    int budget = w * h * 4 + 40;
    stall   = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
    pxl_rdy = 1'b0;
    while (n < w * h && cyc < budget) begin
      step();
      cyc++;
      pxl_rdy = 1'b0;
      if (pxl_vld) begin
        check({tag, "_data"}, 32'(pxl_data[0]), 32'(n % 256));
        check({tag, "_x"},    32'(pxl_x),       32'(n % w));
        check({tag, "_y"},    32'(pxl_y),       32'(n / w));
        if (stall > 0) begin
          stall--;
        end else begin
          pxl_rdy = 1'b1;
          n++;
          stall = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
        end
      end
    end
    check({tag, "_count"}, 32'(n), 32'(w * h));
    step();
    cyc++;
    pxl_rdy = 1'b0;
    check({tag, "_done"},      32'(done),      32'd1);
    check({tag, "_done_rdy"},  32'(start_rdy), 32'd1);
    check({tag, "_done_vld"},  32'(pxl_vld),   32'd0);
    if (exp_steps >= 0) check({tag, "_latency"}, 32'(cyc), 32'(exp_steps));
  endtask

  initial begin
    int guard;
    rst       = 1'b1;
    start_vld = 1'b0;
    img_w     = '0;
    img_h     = '0;
    pxl_rdy   = 1'b0;
    step();
    step();
    check_reset_vals("reset");
    rst = 1'b0;
    step();

    // 4x3 frame, no stalls: pixels in T+3..T+14, Done in T+15.
    start(4, 3);
    check("small_start_rdy", 32'(start_rdy), 32'd0);
    check("small_rd_en",     32'(mem_rd_en), 32'd1);
    check("small_addr0",     32'(mem_addr),  32'd0);
    check("small_st_w",      32'(st_w),      32'd4);
    check("small_st_h",      32'(st_h),      32'd3);
    stream(4, 3, 0, 14, "small");
    step();
    check("small_done_clear", 32'(done), 32'd0);

    // Zero width: immediate Done, no reads, no pixels.
    start(0, 5);
    check("zero_done",      32'(done),      32'd1);
    check("zero_start_rdy", 32'(start_rdy), 32'd1);
    check("zero_rd_en",     32'(mem_rd_en), 32'd0);
    check("zero_vld",       32'(pxl_vld),   32'd0);
    step();
    check("zero_done_clear", 32'(done),      32'd0);
    check("zero_rd_en2",     32'(mem_rd_en), 32'd0);
    check("zero_vld2",       32'(pxl_vld),   32'd0);

    // Start held high mid-frame is ignored, then accepted in the Done cycle.
    start(4, 3);
    img_w     = 10'd2;
    img_h     = 10'd2;
    start_vld = 1'b1;
    check("busy_start_rdy", 32'(start_rdy), 32'd0);
    stream(4, 3, 1, -1, "busy");
    check("busy_st_w_kept", 32'(st_w), 32'd4);
    step();
    start_vld = 1'b0;
    check("busy_next_st_w", 32'(st_w),      32'd2);
    check("busy_next_st_h", 32'(st_h),      32'd2);
    check("busy_next_rd",   32'(mem_rd_en), 32'd1);
    stream(2, 2, 0, 6, "after_busy");

    // Random backpressure on a large frame.
    start(129, 65);
    stream(129, 65, 2, -1, "bp");

    // Reset while pixel 20 of a 10x10 frame is presented.
    start(10, 10);
    pxl_rdy = 1'b1;
    guard   = 0;
    while (!(pxl_vld && pxl_x == 10'd0 && pxl_y == 10'd2) && guard < 100) begin
      step();
      guard++;
    end
    check("mid_reached_px20", 32'(guard < 100), 32'd1);
    rst = 1'b1;
    step();
    check_reset_vals("mid_reset");
    rst     = 1'b0;
    pxl_rdy = 1'b0;
    step();
    check("mid_dropped_vld", 32'(pxl_vld), 32'd0);
    start(2, 2);
    stream(2, 2, 0, 6, "post_reset");

    check("occupancy_limit", 32'(occ_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
